sliding_window_gen: RTL and testbench

// - Producer side of the filter_function pixel interface: turns a raster pixel stream into

---
 rtl/sliding_window_gen.sv | 215 +++++++++++++++++++++
 tb/tb_sliding_window_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_gen.sv
// sliding_window_gen
// Turns a raster pixel stream into packed MASK_WIDTH x MASK_WIDTH windows for
// filter_function. Only fully populated (non-padded) windows are emitted.
//
// Ports:
//   clk        : single clock, all logic on posedge
//   reset_in_n : asynchronous active-low reset
//   pix_in     : raster pixel (unsigned)
//   pix_valid  : pix_in is presented this cycle
//   sof        : start of frame, qualified by pix_valid
//   p          : packed window, slot i = r*MASK_WIDTH + c, r=0 top line, c=0 left column
//   win_valid  : 1-cycle strobe, p holds a new window
//   frame_done : 1-cycle pulse after the last pixel of a frame
//   win_row/win_col (only with WIN_COORD_EN defined) : centre-pixel coordinate of p
//
// Optional feature macro: WIN_COORD_EN
module sliding_window_gen #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_in_n,
    input  logic [PIX_BIT-1:0]                      pix_in,
    input  logic                                    pix_valid,
    input  logic                                    sof,
    output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p,
    output logic                                    win_valid,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_HEIGHT)-1:0]           win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]            win_col,
`endif
    output logic                                    frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN_FIRST = CW'(MASK_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(MASK_WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   col_r, cur_col_s, col_nxt_s;
    logic [RW-1:0]   row_r, cur_row_s, row_nxt_s;
    logic            accept_s, col_end_s, row_end_s, win_hit_s, last_pix_s;
    logic            win_valid_r, frame_done_r;

    // lb_r[0] holds the previous line, lb_r[MASK_WIDTH-2] the oldest one
    logic [PIX_BIT-1:0] lb_r [MASK_WIDTH-1][IMG_WIDTH];
    logic [PIX_BIT-1:0] win_r [MASK_WIDTH][MASK_WIDTH];
    logic [PIX_BIT-1:0] new_col_s [MASK_WIDTH];

    // Accept qualification, coordinate of the current pixel and counter advance
    always_comb begin
        accept_s   = pix_valid && (sof || (state_r == ST_FILL) || (state_r == ST_RUN));
        cur_col_s  = sof ? '0 : col_r;
        cur_row_s  = sof ? '0 : row_r;
        col_end_s  = (cur_col_s == COL_LAST);
        row_end_s  = (cur_row_s == ROW_LAST);
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        if (accept_s) begin
            if (col_end_s) begin
                col_nxt_s = '0;
                row_nxt_s = row_end_s ? '0 : (cur_row_s + 1'b1);
            end else begin
                col_nxt_s = cur_col_s + 1'b1;
                row_nxt_s = cur_row_s;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
        // sof forces (0,0), so it can never complete a window
        win_hit_s  = accept_s && !sof && (state_r == ST_RUN) && (cur_col_s >= COL_WIN_FIRST);
        last_pix_s = accept_s && !sof && (state_r == ST_RUN) && col_end_s && row_end_s;
    end

    // Next-state logic; any accepted sof restarts the frame in FILL
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && sof) begin
                    state_nxt_s = ST_FILL;
                end else if (accept_s && col_end_s && (cur_row_s == ROW_FILL_LAST)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (accept_s && sof) begin
                    state_nxt_s = ST_FILL;
                end else if (last_pix_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and output strobes
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_r      <= ST_IDLE;
            col_r        <= '0;
            row_r        <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            win_valid_r  <= win_hit_s;
            frame_done_r <= last_pix_s;
        end
    end

    // Line buffers: read old column, push new pixel down the chain (no reset)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_r[0][cur_col_s] <= pix_in;
            for (int k = 1; k < MASK_WIDTH - 1; k++) begin
                lb_r[k][cur_col_s] <= lb_r[k-1][cur_col_s];
            end
        end
    end

    // New rightmost window column, oldest line at r=0
    always_comb begin
        for (int r = 0; r < MASK_WIDTH; r++) begin
            new_col_s[r] = pix_in;
        end
        for (int r = 0; r < MASK_WIDTH - 1; r++) begin
            new_col_s[r] = lb_r[MASK_WIDTH-2-r][cur_col_s];
        end
    end

    // Window register array shifts left by one column on every accept
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            for (int r = 0; r < MASK_WIDTH; r++) begin
                for (int c = 0; c < MASK_WIDTH; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < MASK_WIDTH; r++) begin
                for (int c = 0; c < MASK_WIDTH - 1; c++) begin
                    win_r[r][c] <= win_r[r][c+1];
                end
                win_r[r][MASK_WIDTH-1] <= new_col_s[r];
            end
        end
    end

    // Pack the window registers onto p
    always_comb begin
        p = '0;
        for (int r = 0; r < MASK_WIDTH; r++) begin
            for (int c = 0; c < MASK_WIDTH; c++) begin
                p[PIX_BIT*(r*MASK_WIDTH+c) +: PIX_BIT] = win_r[r][c];
            end
        end
    end

    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;

`ifdef WIN_COORD_EN
    logic [RW-1:0] win_row_r;
    logic [CW-1:0] win_col_r;

    // Centre coordinate captured together with each emitted window
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            win_row_r <= '0;
            win_col_r <= '0;
        end else if (win_hit_s) begin
            win_row_r <= cur_row_s - RW'((MASK_WIDTH - 1) / 2);
            win_col_r <= cur_col_s - CW'((MASK_WIDTH - 1) / 2);
        end
    end

    assign win_row = win_row_r;
    assign win_col = win_col_r;
`endif

endmodule

// File: tb/tb_sliding_window_gen.sv
module tb_sliding_window_gen;

    localparam int PB = 8;
    localparam int M  = 7;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int NP = PB * M * M;

    logic          clk;
    logic          reset_in_n;
    logic [PB-1:0] pix_in;
    logic          pix_valid;
    logic          sof;
    logic [NP-1:0] p;
    logic          win_valid;
    logic          frame_done;
`ifdef WIN_COORD_EN
    logic [3:0]    win_row;
    logic [3:0]    win_col;
`endif

    sliding_window_gen #(
        .PIX_BIT    (PB),
        .MASK_WIDTH (M),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .reset_in_n (reset_in_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p          (p),
        .win_valid  (win_valid),
`ifdef WIN_COORD_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as a 2-D image plus a raster position
    int            m_img [H][W];
    int            m_pos;
    bit            m_in_frame;
    bit            m_hold;
    logic [NP-1:0] m_hold_p;
    int            m_cr, m_cc;

    // Observation statistics
    int            tot_win, tot_fd, frame_win;
    logic [NP-1:0] first_p, last_p;

    typedef struct {
        logic          v;
        logic          s;
        logic [PB-1:0] d;
        logic          exp_wv;
        logic          exp_fd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_in_frame = 1'b0;
        m_hold     = 1'b0;
        m_hold_p   = '0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [PB-1:0] d,
                              output logic ewv, output logic efd);
        int r, c;
        ewv = 1'b0;
        efd = 1'b0;
        if (v && (s || m_in_frame)) begin
            if (s) m_pos = 0;
            r = m_pos / W;
            c = m_pos % W;
            m_img[r][c] = int'(d);
            m_hold = 1'b0;
            if (r >= M - 1 && c >= M - 1) begin
                ewv = 1'b1;
                for (int wr = 0; wr < M; wr++)
                    for (int wc = 0; wc < M; wc++)
                        m_hold_p[PB*(wr*M+wc) +: PB] = PB'(m_img[r-(M-1)+wr][c-(M-1)+wc]);
                m_hold = 1'b1;
                m_cr = r - (M - 1) / 2;
                m_cc = c - (M - 1) / 2;
            end
            if (m_pos == W * H - 1) begin
                efd = 1'b1;
                m_in_frame = 1'b0;
            end else begin
                m_in_frame = 1'b1;
            end
            m_pos++;
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [PB-1:0] d);
        logic ewv, efd;
        pix_valid = v;
        sof       = s;
        pix_in    = d;
        model_step(v, s, d, ewv, efd);
        @(posedge clk);
        #1;
        chk("win_valid", NP'(win_valid), NP'(ewv));
        chk("frame_done", NP'(frame_done), NP'(efd));
        if (m_hold) begin
            chk("window", p, m_hold_p);
`ifdef WIN_COORD_EN
            if (ewv) begin
                chk("win_row", NP'(win_row), NP'(m_cr));
                chk("win_col", NP'(win_col), NP'(m_cc));
            end
`endif
        end
        if (win_valid) begin
            tot_win++;
            frame_win++;
            if (frame_win == 1) first_p = p;
            last_p = p;
        end
        if (frame_done) begin
            tot_fd++;
            chk("fd_with_last_win", NP'(win_valid), NP'(1'b1));
        end
    endtask

    task automatic reset_stats();
        tot_win   = 0;
        tot_fd    = 0;
        frame_win = 0;
        first_p   = '0;
        last_p    = '0;
    endtask

    // Ramp frame (pixel = raster index), optional random idle gaps; stops after n_pix pixels
    task automatic send_frame(input int gap_pct, input int n_pix);
        int g;
        for (int i = 0; i < n_pix; i++) begin
            g = (int'($urandom_range(99, 0)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
            repeat (g) cycle(1'b0, 1'($urandom_range(1, 0)), PB'($urandom));
            cycle(1'b1, (i == 0), PB'(i));
        end
    endtask

    task automatic check_clean_frame(input string tag);
        chk({tag, "_win_count"}, NP'(frame_win), NP'(100));
        chk({tag, "_first_lo"},  NP'(first_p[7:0]), NP'(0));
        chk({tag, "_first_hi"},  NP'(first_p[391:384]), NP'(102));
        chk({tag, "_last_lo"},   NP'(last_p[7:0]), NP'(153));
        chk({tag, "_last_hi"},   NP'(last_p[391:384]), NP'(255));
    endtask

    initial begin
        reset_in_n = 1'b0;
        pix_valid  = 1'b0;
        sof        = 1'b0;
        pix_in     = '0;
        model_reset();
        reset_stats();

        // Reset state
        #12;
        chk("reset_p", p, '0);
        chk("reset_wv", NP'(win_valid), NP'(1'b0));
        chk("reset_fd", NP'(frame_done), NP'(1'b0));
        @(negedge clk);
        reset_in_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle behaviour: no sof accepted, so nothing may happen
        tbl[0] = '{1'b1, 1'b0, 8'd17,  1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'd200, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'd5,   1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'd9,   1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd255, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'd77,  1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'd1,   1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 8'd128, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            pix_valid = tbl[i].v;
            sof       = tbl[i].s;
            pix_in    = tbl[i].d;
            @(posedge clk);
            #1;
            chk("idle_wv", NP'(win_valid), NP'(tbl[i].exp_wv));
            chk("idle_fd", NP'(frame_done), NP'(tbl[i].exp_fd));
            chk("idle_p", p, '0);
        end

        // Gap-free frame
        reset_stats();
        send_frame(0, W * H);
        cycle(1'b0, 1'b0, 8'd0);
        check_clean_frame("clean");
        chk("clean_fd_count", NP'(tot_fd), NP'(1));

        // Pixels without sof after the frame are ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, PB'($urandom));

        // Random gaps
        reset_stats();
        send_frame(50, W * H);
        cycle(1'b0, 1'b0, 8'd0);
        check_clean_frame("gaps");
        chk("gaps_fd_count", NP'(tot_fd), NP'(1));

        // sof re-asserted at (10,3)
        reset_stats();
        send_frame(30, 10 * W + 3);
        chk("abort_fd_count", NP'(tot_fd), NP'(0));
        reset_stats();
        send_frame(0, W * H);
        cycle(1'b0, 1'b0, 8'd0);
        check_clean_frame("restart");
        chk("restart_fd_count", NP'(tot_fd), NP'(1));

        // Reset mid-RUN, just after a window strobe
        reset_stats();
        send_frame(0, 9 * W + 8);
        chk("pre_reset_wv", NP'(win_valid), NP'(1'b1));
        #2;
        reset_in_n = 1'b0;
        #1;
        chk("midreset_p", p, '0);
        chk("midreset_wv", NP'(win_valid), NP'(1'b0));
        chk("midreset_fd", NP'(frame_done), NP'(1'b0));
        model_reset();
        #3;
        reset_in_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'd33);
        reset_stats();
        send_frame(0, W * H);
        cycle(1'b0, 1'b0, 8'd0);
        check_clean_frame("postreset");

        // Back-to-back frames: second sof lands in the cycle after the last pixel
        reset_stats();
        send_frame(0, W * H);
        frame_win = 0;
        first_p   = '0;
        send_frame(0, W * H);
        cycle(1'b0, 1'b0, 8'd0);
        chk("b2b_win_total", NP'(tot_win), NP'(200));
        chk("b2b_fd_total", NP'(tot_fd), NP'(2));
        chk("b2b_first_lo", NP'(first_p[7:0]), NP'(0));
        chk("b2b_first_hi", NP'(first_p[391:384]), NP'(102));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
